// File: rtl/pll_lock_supervisor.sv
// PLL bring-up / lock supervisor on the reference clock domain.
// Sequences PLL reset, qualifies lock, releases system reset, and retries or faults.
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES = 24,
  parameter int LOCK_TIMEOUT   = 24000,
  parameter int STABLE_CYCLES  = 2400,
  parameter int MAX_RETRIES    = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       extlock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] relock_count
);

  localparam int CNT_MAX0 = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX  = (CNT_MAX0 > STABLE_CYCLES) ? CNT_MAX0 : STABLE_CYCLES;
  localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PLLRST = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d, retry_inc;
  logic [7:0]       relock_q, relock_d;
  logic             sync_q, lock_s;

  // extlock is the only asynchronous input; two flops before anything looks at it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync_q <= extlock;
      lock_s <= sync_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    relock_d  = relock_q;
    retry_inc = retry_q + 4'd1;
    if (restart) begin
      state_d = ST_PLLRST;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_PLLRST: if (cnt_q == RST_LAST) state_d = ST_WAIT;
        ST_WAIT: begin
          if (lock_s) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TMO_LAST) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_MAX) ? ST_FAULT : ST_PLLRST;
          end
        end
        // a dropout while qualifying falls back to WAIT without costing a retry
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT;
          end else if (cnt_q == STB_LAST) begin
            state_d = ST_RUN;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_PLLRST;
            if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_PLLRST;
      endcase
    end

    // RUN and FAULT hold the counter so it can never wrap while parked there
    if (restart || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (state_q == ST_PLLRST || state_q == ST_WAIT || state_q == ST_STABLE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_PLLRST;
      cnt_q     <= '0;
      retry_q   <= '0;
      relock_q  <= '0;
      pll_reset <= 1'b1;
      sys_rst_n <= 1'b0;
      locked    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      relock_q  <= relock_d;
      // outputs decoded from the next state so they move on the same edge as state
      pll_reset <= (state_d == ST_PLLRST) || (state_d == ST_FAULT);
      sys_rst_n <= (state_d == ST_RUN);
      locked    <= (state_d == ST_RUN);
      fault     <= (state_d == ST_FAULT);
    end
  end

  assign state        = state_q;
  assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: expectations are queued with the stimulus
// and popped on the cycle they fall due.
module tb_pll_lock_supervisor;

  logic       clk, rst_n, extlock, restart;
  logic       pll_reset, sys_rst_n, locked, fault;
  logic [2:0] state;
  logic [7:0] relock_count;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(16), .STABLE_CYCLES(8), .MAX_RETRIES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .extlock(extlock), .restart(restart),
    .pll_reset(pll_reset), .sys_rst_n(sys_rst_n), .locked(locked), .fault(fault),
    .state(state), .relock_count(relock_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [14:0] obs = {state, pll_reset, sys_rst_n, locked, fault, relock_count};

  typedef struct {
    int          at;
    string       nm;
    logic [14:0] v;
    int          rt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [14:0] ev(input int st, input bit pr, input bit sr,
                                     input bit lk, input bit ft, input int rc);
    return {3'(st), pr, sr, lk, ft, 8'(rc)};
  endfunction

  function automatic exp_t mk(input int at, input string nm, input logic [14:0] v, input int rt);
    exp_t e;
    e.at = at; e.nm = nm; e.v = v; e.rt = rt;
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; extlock = 1'b0; restart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sb.push_back(mk(0, "reset_vals", ev(0, 1, 0, 0, 0, 0), 0));
    while (sb.size() > 0 && sb[0].at == 0) begin
      e = sb.pop_front();
      n_tests++;
      if (obs !== e.v || (e.rt >= 0 && dut.retry_q !== 4'(e.rt))) begin
        n_fail++;
        $display("FAIL %s: got st=%0d pr/sr/lk/ft=%b rc=%0d retry=%0d, expected st=%0d pr/sr/lk/ft=%b rc=%0d retry=%0d",
                 e.nm, obs[14:12], obs[11:8], obs[7:0], dut.retry_q, e.v[14:12], e.v[11:8], e.v[7:0], e.rt);
      end
    end
  endtask

  task automatic test_bringup();
    exp_t e;
    sb.push_back(mk(3,  "bringup_pllrst_held", ev(0, 1, 0, 0, 0, 0), -1));
    sb.push_back(mk(4,  "bringup_wait",        ev(1, 0, 0, 0, 0, 0), -1));
    sb.push_back(mk(12, "bringup_still_wait",  ev(1, 0, 0, 0, 0, 0), -1));
    sb.push_back(mk(13, "bringup_stable",      ev(2, 0, 0, 0, 0, 0), -1));
    sb.push_back(mk(20, "bringup_pre_release", ev(2, 0, 0, 0, 0, 0), -1));
    sb.push_back(mk(21, "bringup_run",         ev(3, 0, 1, 1, 0, 0), 0));
    rst_n = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].at == c) begin
        e = sb.pop_front();
        n_tests++;
        if (obs !== e.v || (e.rt >= 0 && dut.retry_q !== 4'(e.rt))) begin
          n_fail++;
          $display("FAIL %s: got st=%0d pr/sr/lk/ft=%b rc=%0d retry=%0d, expected st=%0d pr/sr/lk/ft=%b rc=%0d retry=%0d",
                   e.nm, obs[14:12], obs[11:8], obs[7:0], dut.retry_q, e.v[14:12], e.v[11:8], e.v[7:0], e.rt);
        end
      end
      if (c == 10) extlock = 1'b1;
    end
  endtask

  // restart from RUN with lock gone, burn one timeout so retry=1, then glitch in STABLE
  task automatic test_glitch_stable();
    exp_t e;
    sb.push_back(mk(1,  "glitch_restart_pllrst", ev(0, 1, 0, 0, 0, 0), 0));
    sb.push_back(mk(21, "glitch_first_timeout",  ev(0, 1, 0, 0, 0, 0), 1));
    sb.push_back(mk(25, "glitch_wait2",          ev(1, 0, 0, 0, 0, 0), 1));
    sb.push_back(mk(27, "glitch_wait2_hold",     ev(1, 0, 0, 0, 0, 0), 1));
    sb.push_back(mk(28, "glitch_stable",         ev(2, 0, 0, 0, 0, 0), 1));
    sb.push_back(mk(35, "glitch_stable_cnt7",    ev(2, 0, 0, 0, 0, 0), 1));
    sb.push_back(mk(36, "glitch_back_to_wait",   ev(1, 0, 0, 0, 0, 0), 1));
    sb.push_back(mk(37, "glitch_stable_again",   ev(2, 0, 0, 0, 0, 0), 1));
    sb.push_back(mk(44, "glitch_pre_release",    ev(2, 0, 0, 0, 0, 0), 1));
    sb.push_back(mk(45, "glitch_run",            ev(3, 0, 1, 1, 0, 0), 0));
    extlock = 1'b0; restart = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].at == c) begin
        e = sb.pop_front();
        n_tests++;
        if (obs !== e.v || (e.rt >= 0 && dut.retry_q !== 4'(e.rt))) begin
          n_fail++;
          $display("FAIL %s: got st=%0d pr/sr/lk/ft=%b rc=%0d retry=%0d, expected st=%0d pr/sr/lk/ft=%b rc=%0d retry=%0d",
                   e.nm, obs[14:12], obs[11:8], obs[7:0], dut.retry_q, e.v[14:12], e.v[11:8], e.v[7:0], e.rt);
        end
      end
      if (c == 1)  restart = 1'b0;
      if (c == 25) extlock = 1'b1;
      if (c == 33) extlock = 1'b0;
      if (c == 34) extlock = 1'b1;
    end
  endtask

  task automatic test_lock_loss();
    exp_t e;
    int   rc_exp;
    for (int i = 1; i <= 300; i++) begin
      rc_exp = (i > 255) ? 255 : i;
      sb.push_back(mk(2,  "lockloss_still_run", ev(3, 0, 1, 1, 0, (i - 1 > 255) ? 255 : i - 1), -1));
      sb.push_back(mk(3,  "lockloss_pllrst",    ev(0, 1, 0, 0, 0, rc_exp), -1));
      sb.push_back(mk(16, "lockloss_rerun",     ev(3, 0, 1, 1, 0, rc_exp), 0));
      extlock = 1'b0;
      for (int c = 1; c <= 16; c++) begin
        @(posedge clk); #1;
        while (sb.size() > 0 && sb[0].at == c) begin
          e = sb.pop_front();
          n_tests++;
          if (obs !== e.v || (e.rt >= 0 && dut.retry_q !== 4'(e.rt))) begin
            n_fail++;
            $display("FAIL %s[%0d]: got st=%0d pr/sr/lk/ft=%b rc=%0d retry=%0d, expected st=%0d pr/sr/lk/ft=%b rc=%0d retry=%0d",
                     e.nm, i, obs[14:12], obs[11:8], obs[7:0], dut.retry_q, e.v[14:12], e.v[11:8], e.v[7:0], e.rt);
          end
        end
        if (c == 3) extlock = 1'b1;
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    sb.push_back(mk(0, "async_reset_now",  ev(0, 1, 0, 0, 0, 0), 0));
    sb.push_back(mk(1, "async_reset_held", ev(0, 1, 0, 0, 0, 0), 0));
    #2;
    rst_n = 1'b0;
    #1;
    for (int c = 0; c <= 1; c++) begin
      if (c == 1) begin
        extlock = 1'b0;
        @(posedge clk); #1;
      end
      while (sb.size() > 0 && sb[0].at == c) begin
        e = sb.pop_front();
        n_tests++;
        if (obs !== e.v || (e.rt >= 0 && dut.retry_q !== 4'(e.rt))) begin
          n_fail++;
          $display("FAIL %s: got st=%0d pr/sr/lk/ft=%b rc=%0d retry=%0d, expected st=%0d pr/sr/lk/ft=%b rc=%0d retry=%0d",
                   e.nm, obs[14:12], obs[11:8], obs[7:0], dut.retry_q, e.v[14:12], e.v[11:8], e.v[7:0], e.rt);
        end
      end
    end
  endtask

  task automatic test_timeout_fault();
    exp_t e;
    sb.push_back(mk(3,  "tmo_pulse1",       ev(0, 1, 0, 0, 0, 0), 0));
    sb.push_back(mk(4,  "tmo_wait1",        ev(1, 0, 0, 0, 0, 0), 0));
    sb.push_back(mk(19, "tmo_wait1_end",    ev(1, 0, 0, 0, 0, 0), 0));
    sb.push_back(mk(20, "tmo_pulse2",       ev(0, 1, 0, 0, 0, 0), 1));
    sb.push_back(mk(23, "tmo_pulse2_end",   ev(0, 1, 0, 0, 0, 0), 1));
    sb.push_back(mk(24, "tmo_wait2",        ev(1, 0, 0, 0, 0, 0), 1));
    sb.push_back(mk(39, "tmo_wait2_end",    ev(1, 0, 0, 0, 0, 0), 1));
    sb.push_back(mk(40, "tmo_fault",        ev(4, 1, 0, 0, 1, 0), 2));
    sb.push_back(mk(50, "tmo_fault_held",   ev(4, 1, 0, 0, 1, 0), 2));
    rst_n = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].at == c) begin
        e = sb.pop_front();
        n_tests++;
        if (obs !== e.v || (e.rt >= 0 && dut.retry_q !== 4'(e.rt))) begin
          n_fail++;
          $display("FAIL %s: got st=%0d pr/sr/lk/ft=%b rc=%0d retry=%0d, expected st=%0d pr/sr/lk/ft=%b rc=%0d retry=%0d",
                   e.nm, obs[14:12], obs[11:8], obs[7:0], dut.retry_q, e.v[14:12], e.v[11:8], e.v[7:0], e.rt);
        end
      end
    end
  endtask

  // leave FAULT via restart, then land a restart on the edge that would otherwise fault
  task automatic test_restart();
    exp_t e;
    sb.push_back(mk(1,  "rst_from_fault",     ev(0, 1, 0, 0, 0, 0), 0));
    sb.push_back(mk(20, "rst_wait_end",       ev(1, 0, 0, 0, 0, 0), 0));
    sb.push_back(mk(21, "rst_timeout1",       ev(0, 1, 0, 0, 0, 0), 1));
    sb.push_back(mk(40, "rst_wait2_end",      ev(1, 0, 0, 0, 0, 0), 1));
    sb.push_back(mk(41, "rst_beats_fault",    ev(0, 1, 0, 0, 0, 0), 0));
    sb.push_back(mk(42, "rst_pllrst_cont",    ev(0, 1, 0, 0, 0, 0), 0));
    sb.push_back(mk(45, "rst_wait_again",     ev(1, 0, 0, 0, 0, 0), 0));
    restart = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].at == c) begin
        e = sb.pop_front();
        n_tests++;
        if (obs !== e.v || (e.rt >= 0 && dut.retry_q !== 4'(e.rt))) begin
          n_fail++;
          $display("FAIL %s: got st=%0d pr/sr/lk/ft=%b rc=%0d retry=%0d, expected st=%0d pr/sr/lk/ft=%b rc=%0d retry=%0d",
                   e.nm, obs[14:12], obs[11:8], obs[7:0], dut.retry_q, e.v[14:12], e.v[11:8], e.v[7:0], e.rt);
        end
      end
      if (c == 1)  restart = 1'b0;
      if (c == 40) restart = 1'b1;
      if (c == 41) restart = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_glitch_stable();
    test_lock_loss();
    test_async_reset();
    test_timeout_fault();
    test_restart();
    n_tests++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
